fft_out_reorder: RTL and testbench



---
 rtl/fft_out_reorder_if.sv | 23 ++
 rtl/fft_out_reorder.sv | 93 +++++++++
 tb/tb_fft_out_reorder.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_out_reorder_if.sv
// Handshake bundle between the FFT core, the output reorder stage and the downstream consumer.
// The slave modport is the reorder block's view; the master modport is the driver/consumer view.
interface fft_out_reorder_if #(
    parameter int DATA_W = 34
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fft_out_reorder.sv
// FFT output reorder: writes bit-reversed samples into a ping-pong bank pair and
// streams each completed frame back out in natural index order.
module fft_out_reorder #(
    parameter int N_LOG2 = 3,
    parameter int DATA_W = 34
) (
    input logic            clk,
    input logic            rst_n,
    fft_out_reorder_if.slave bus
);
    localparam int N = 1 << N_LOG2;
    localparam logic [N_LOG2-1:0] LAST_IDX = N_LOG2'(N - 1);

    logic              wr_bank_reg;
    logic              rd_bank_reg;
    logic [N_LOG2-1:0] wr_cnt_reg;
    logic [N_LOG2-1:0] rd_cnt_reg;
    logic [1:0]        full_reg;
    logic [1:0]        full_next;
    logic [N_LOG2-1:0] wr_addr;
    logic [DATA_W-1:0] mem_reg [2][N];

    logic wr_fire;
    logic rd_fire;
    logic wr_wrap;
    logic rd_wrap;

    // Write address is the bit-reversed arrival count.
    genvar gi;
    generate
        for (gi = 0; gi < N_LOG2; gi++) begin : g_bitrev
            assign wr_addr[gi] = wr_cnt_reg[N_LOG2-1-gi];
        end
    endgenerate

    assign bus.in_ready  = !full_reg[wr_bank_reg];
    assign bus.out_valid = full_reg[rd_bank_reg];
    assign bus.out_data  = mem_reg[rd_bank_reg][rd_cnt_reg];
    assign bus.out_last  = full_reg[rd_bank_reg] && (rd_cnt_reg == LAST_IDX);

    assign wr_fire = bus.in_valid && !full_reg[wr_bank_reg];
    assign rd_fire = full_reg[rd_bank_reg] && bus.out_ready;
    assign wr_wrap = wr_fire && (wr_cnt_reg == LAST_IDX);
    assign rd_wrap = rd_fire && (rd_cnt_reg == LAST_IDX);

    // Set and clear always target different banks: a bank being written is never full.
    always_comb begin
        full_next = full_reg;
        if (wr_wrap) begin
            full_next[wr_bank_reg] = 1'b1;
        end
        if (rd_wrap) begin
            full_next[rd_bank_reg] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            wr_cnt_reg  <= '0;
            rd_cnt_reg  <= '0;
            full_reg    <= 2'b00;
        end else begin
            full_reg <= full_next;
            if (wr_fire) begin
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
            end
            if (wr_wrap) begin
                wr_bank_reg <= !wr_bank_reg;
            end
            if (rd_fire) begin
                rd_cnt_reg <= rd_cnt_reg + 1'b1;
            end
            if (rd_wrap) begin
                rd_bank_reg <= !rd_bank_reg;
            end
        end
    end

    // Banks are cleared on reset so out_data reads zero until the first frame lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < N; e++) begin
                    mem_reg[b][e] <= '0;
                end
            end
        end else if (wr_fire) begin
            mem_reg[wr_bank_reg][wr_addr] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder: vector table, directed multi-cycle sequences and a
// randomized run checked by a frame-level reference model.
module tb_fft_out_reorder;
    localparam int N_LOG2 = 3;
    localparam int N      = 1 << N_LOG2;
    localparam int DW     = 34;

    logic clk;
    logic rst_n;

    fft_out_reorder_if #(.DATA_W(DW)) bus ();

    fft_out_reorder #(.N_LOG2(N_LOG2), .DATA_W(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int bitrev(input int k);
        int r = 0;
        for (int i = 0; i < N_LOG2; i++) r = (r << 1) | ((k >> i) & 1);
        return r;
    endfunction

    // ---------------- reference model (frame level) ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] part_q[$];
    int            frames_buf = 0;
    int            in_count   = 0;
    int            out_count  = 0;
    int            last_count = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            part_q.delete();
            frames_buf = 0;
            prev_stall = 1'b0;
        end else begin
            check("mon_in_ready", 64'(bus.in_ready), 64'(frames_buf < 2));
            check("mon_out_valid", 64'(bus.out_valid), 64'(frames_buf >= 1));
            if (!bus.out_valid) check("mon_last_idle", 64'(bus.out_last), 64'(0));
            if (prev_stall) begin
                check("stall_data", 64'(bus.out_data), 64'(prev_data));
                check("stall_last", 64'(bus.out_last), 64'(prev_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                out_count++;
                if (bus.out_last) last_count++;
                if (exp_q.size() == 0) begin
                    check("mon_unexpected_out", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("mon_out_data", 64'(bus.out_data), 64'(e.d));
                    check("mon_out_last", 64'(bus.out_last), 64'(e.l));
                    if (e.l) frames_buf--;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                in_count++;
                part_q.push_back(bus.in_data);
                if (part_q.size() == N) begin
                    // arrival position bitrev(k) carries natural index k
                    for (int k = 0; k < N; k++) begin
                        exp_t e;
                        e.d = part_q[bitrev(k)];
                        e.l = (k == N - 1);
                        exp_q.push_back(e);
                    end
                    part_q.delete();
                    frames_buf++;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input int max_gap);
        int  tries;
        logic acc;
        repeat ($urandom_range(0, max_gap)) begin
            bus.in_valid = 1'b0;
            step();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tries = 0;
        forever begin
            acc = bus.in_ready;
            step();
            if (acc) break;
            tries++;
            if (tries > 1000) begin
                check("send_timeout", 64'(1), 64'(0));
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200 && frames_buf != 0; i++) step();
        check("drain_empty", 64'(frames_buf), 64'(0));
    endtask

    typedef struct {
        logic          in_valid;
        logic [DW-1:0] in_data;
        logic          out_ready;
        logic          exp_in_ready;
        logic          exp_out_valid;
        logic [DW-1:0] exp_out_data;
        logic          exp_out_last;
    } vec_t;

    vec_t vecs[18];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   base_in;
        int   base_out;
        int   base_last;
        logic send_done;

        // Single frame table: 8 bit-reversed inputs, then 8 natural outputs.
        for (int i = 0; i < N; i++)
            vecs[i] = '{1'b1, DW'(bitrev(i)), 1'b1, 1'b1, 1'b0, '0, 1'b0};
        for (int k = 0; k < N; k++)
            vecs[N+k] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, DW'(k), (k == N - 1)};
        vecs[16] = '{1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 1'b0};
        vecs[17] = '{1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 1'b0};

        // Test 1: reset
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_last", 64'(bus.out_last), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("post_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("post_rst_out_data", 64'(bus.out_data), 64'(0));

        // Test 2: vector table
        for (int i = 0; i < 18; i++) begin
            bus.in_valid  = vecs[i].in_valid;
            bus.in_data   = vecs[i].in_data;
            bus.out_ready = vecs[i].out_ready;
            check($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'(vecs[i].exp_in_ready));
            check($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_out_valid));
            check($sformatf("vec%0d_out_last", i), 64'(bus.out_last), 64'(vecs[i].exp_out_last));
            if (vecs[i].exp_out_valid)
                check($sformatf("vec%0d_out_data", i), 64'(bus.out_data), 64'(vecs[i].exp_out_data));
            step();
        end
        $display("test2 single frame done, checks=%0d", n_checks);

        // Test 3: three back-to-back frames, continuous streaming
        bus.out_ready = 1'b1;
        for (int c = 0; c < 36; c++) begin
            bus.in_valid = (c < 24);
            bus.in_data  = DW'(bitrev(c % N));
            check($sformatf("b2b%0d_in_ready", c), 64'(bus.in_ready), 64'(1));
            check($sformatf("b2b%0d_out_valid", c), 64'(bus.out_valid), 64'(c >= 8 && c < 32));
            if (c >= 8 && c < 32) begin
                check($sformatf("b2b%0d_out_data", c), 64'(bus.out_data), 64'((c - 8) % N));
                check($sformatf("b2b%0d_out_last", c), 64'(bus.out_last), 64'(((c - 8) % N) == N - 1));
            end
            step();
        end
        bus.in_valid = 1'b0;
        $display("test3 back-to-back done, checks=%0d", n_checks);

        // Test 4: backpressure with two frames buffered
        bus.out_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(bitrev(c % N) + ((c >= N) ? 8 : 0));
            check($sformatf("bp%0d_in_ready", c), 64'(bus.in_ready), 64'(1));
            step();
        end
        bus.in_data = DW'(16);
        for (int h = 0; h < 3; h++) begin
            check($sformatf("bp_hold%0d_in_ready", h), 64'(bus.in_ready), 64'(0));
            check($sformatf("bp_hold%0d_out_valid", h), 64'(bus.out_valid), 64'(1));
            check($sformatf("bp_hold%0d_out_data", h), 64'(bus.out_data), 64'(0));
            step();
        end
        bus.out_ready = 1'b1;
        for (int r = 0; r < N; r++) begin
            check($sformatf("bp_rd%0d_in_ready", r), 64'(bus.in_ready), 64'(0));
            check($sformatf("bp_rd%0d_out_data", r), 64'(bus.out_data), 64'(r));
            step();
        end
        check("bp_17th_in_ready", 64'(bus.in_ready), 64'(1));
        check("bp_frame2_first", 64'(bus.out_data), 64'(8));
        step();
        bus.in_valid = 1'b0;
        for (int k = 1; k < N; k++) send(DW'(16 + bitrev(k)), 0);
        drain();
        $display("test4 backpressure done, checks=%0d", n_checks);

        // Test 5: random gaps and random out_ready over 10 frames
        base_in   = in_count;
        base_out  = out_count;
        send_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 10; f++)
                    for (int k = 0; k < N; k++)
                        send({2'($urandom_range(0, 3)), 32'($urandom())}, 3);
                send_done = 1'b1;
            end
            begin
                for (int i = 0; i < 5000 && !(send_done && frames_buf == 0); i++) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    step();
                end
                bus.out_ready = 1'b1;
            end
        join
        check("rand_in_count", 64'(in_count - base_in), 64'(80));
        check("rand_out_count", 64'(out_count - base_out), 64'(80));
        $display("test5 random done, checks=%0d", n_checks);

        // Test 6: reset with one buffered frame and a partial frame in flight
        bus.out_ready = 1'b0;
        for (int k = 0; k < N; k++) send(DW'(64 + bitrev(k)), 0);
        for (int k = 0; k < 5; k++) send(DW'(128 + bitrev(k)), 0);
        #2;
        check("pre_rst_out_valid", 64'(bus.out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("async_rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("async_rst_out_last", 64'(bus.out_last), 64'(0));
        check("async_rst_out_data", 64'(bus.out_data), 64'(0));
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
        base_out  = out_count;
        base_last = last_count;
        bus.out_ready = 1'b1;
        for (int k = 0; k < N; k++) send(DW'(bitrev(k)), 0);
        drain();
        check("post_rst_frame_outs", 64'(out_count - base_out), 64'(8));
        check("post_rst_frame_lasts", 64'(last_count - base_last), 64'(1));
        $display("test6 mid-frame reset done, checks=%0d", n_checks);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
